// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================
// Module : shift_pkg - shared types/constants for shift_seq
// Rev    : 1.0
// ============================================================
package shift_pkg;

  localparam int WIDTH    = 8;
  localparam int STEP_MAX = 7;

  localparam logic DIR_R = 1'b0;
  localparam logic DIR_L = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/shift_seq_if.sv
`default_nettype none
// ============================================================
// Module : shift_seq_if - request/response handshake bundle
// Rev    : 1.0
// ============================================================
interface shift_seq_if import shift_pkg::*; #(
  parameter int AMT_W = 5
) ();

  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_din;
  logic [AMT_W-1:0] req_amt;
  logic             req_lr;
  logic             req_al;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_dout;

  modport master (
    output req_valid, req_din, req_amt, req_lr, req_al, resp_ready,
    input  req_ready, resp_valid, resp_dout
  );

  modport slave (
    input  req_valid, req_din, req_amt, req_lr, req_al, resp_ready,
    output req_ready, resp_valid, resp_dout
  );

endinterface
`default_nettype wire

// File: rtl/barrel_shift8.sv
`default_nettype none
// ============================================================
// Module : barrel_shift8 - combinational single-pass 8-bit shifter
// Rev    : 1.0
// ============================================================
module barrel_shift8 import shift_pkg::*; (
  input  wire logic [7:0] din,
  input  wire logic [2:0] shamt,
  input  wire logic       LR,
  input  wire logic       AL,
  output logic      [7:0] dout
);

  // Left shifts always zero-fill; AL only affects right shifts.
  always_comb begin
    dout = din >> shamt;
    if (LR == DIR_L) begin
      dout = din << shamt;
    end else if (AL) begin
      dout = 8'($signed(din) >>> shamt);
    end
  end

endmodule
`default_nettype wire

// File: rtl/shift_seq.sv
`default_nettype none
// ============================================================
// Module : shift_seq - multi-pass sequencer around barrel_shift8
// Rev    : 1.0
// ============================================================
module shift_seq import shift_pkg::*; #(
  parameter int AMT_W = 5
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  shift_seq_if.slave  bus,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_SHIFT = SHIFT;
  localparam logic [1:0] ST_DONE  = DONE;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_acc;
  logic [AMT_W-1:0] r_rem;
  logic             r_lr;
  logic             r_al;

  logic [2:0]       w_step;
  logic [AMT_W-1:0] w_rem_next;
  logic [WIDTH-1:0] w_shifted;

  // Each pass consumes at most STEP_MAX positions; rem therefore never underflows.
  always_comb begin
    w_step     = (r_rem > AMT_W'(STEP_MAX)) ? 3'(STEP_MAX) : r_rem[2:0];
    w_rem_next = r_rem - AMT_W'(w_step);
  end

  barrel_shift8 u_shift (
    .din   (r_acc),
    .shamt (w_step),
    .LR    (r_lr),
    .AL    (r_al),
    .dout  (w_shifted)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_rem   <= '0;
      r_lr    <= 1'b0;
      r_al    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            r_acc   <= bus.req_din;
            r_rem   <= bus.req_amt;
            r_lr    <= bus.req_lr;
            r_al    <= bus.req_al;
            r_state <= (bus.req_amt == '0) ? ST_DONE : ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_acc <= w_shifted;
          r_rem <= w_rem_next;
          if (w_rem_next == '0) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.resp_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode straight from state so an asynchronous reset shows at once.
  assign bus.req_ready  = (r_state == ST_IDLE);
  assign bus.resp_valid = (r_state == ST_DONE);
  assign bus.resp_dout  = (r_state == ST_DONE) ? r_acc : '0;
  assign busy           = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_shift_seq.sv
`default_nettype none
// ============================================================
// Module : tb_shift_seq - self-checking bench for shift_seq
// Rev    : 1.0
// ============================================================
module tb_shift_seq;
  import shift_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  shift_seq_if #(.AMT_W(5)) bus ();

  shift_seq #(.AMT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  typedef struct {
    logic [7:0] din;
    logic [4:0] amt;
    logic       lr;
    logic       al;
    int         stall;
    logic [7:0] exp;
    int         exp_lat;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model(input logic [7:0] d, input int a,
                                       input logic lr, input logic al);
    int v;
    if (lr) v = (a >= 8) ? 0 : ((int'(d) << a) & 255);
    else if (al && d[7]) v = ((int'(d) - 256) >>> a) & 255;
    else v = int'(d) >> a;
    return v[7:0];
  endfunction

  function automatic int model_lat(input int a);
    return 1 + (a + 6) / 7;
  endfunction

  // Runs one transaction; called just after a rising edge.
  task automatic run_req(input logic [7:0] d, input logic [4:0] a, input logic lr,
                         input logic al, input int stall, output logic [7:0] dout,
                         output int lat, output int nbusy);
    logic [7:0] held;
    int w;
    w = 0;
    while (!bus.req_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    check("req_ready_idle", int'(bus.req_ready), 1);
    bus.req_valid = 1'b1; bus.req_din = d; bus.req_amt = a;
    bus.req_lr = lr; bus.req_al = al; bus.resp_ready = 1'b0;
    @(posedge clk); #1;
    // Later changes to req_* must have no effect.
    bus.req_valid = 1'b0; bus.req_din = 8'($urandom);
    bus.req_amt = 5'($urandom); bus.req_lr = ~lr; bus.req_al = ~al;
    lat = 1;
    nbusy = busy ? 1 : 0;
    while (!bus.resp_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
      if (busy) nbusy++;
    end
    dout = bus.resp_dout;
    held = bus.resp_dout;
    for (int i = 0; i < stall; i++) begin
      bus.req_valid = 1'b1;
      @(posedge clk); #1;
      if (busy) nbusy++;
      check("stall_valid", int'(bus.resp_valid), 1);
      check("stall_dout", int'(bus.resp_dout), int'(held));
      check("stall_req_ready", int'(bus.req_ready), 0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    check("post_hs_idle", int'({busy, bus.resp_valid, bus.req_ready}), 1);
    check("post_hs_dout", int'(bus.resp_dout), 0);
    bus.req_valid = 1'b0;
  endtask

  vec_t vecs[12];

  initial begin
    logic [7:0] got;
    int lat, nbusy;
    vecs[0]  = '{8'h96, 5'd0,  1'b0, 1'b0, 0, 8'h96, 1};
    vecs[1]  = '{8'h96, 5'd3,  1'b0, 1'b0, 0, 8'h12, 2};
    vecs[2]  = '{8'h96, 5'd3,  1'b0, 1'b1, 0, 8'hF2, 2};
    vecs[3]  = '{8'h81, 5'd9,  1'b1, 1'b0, 0, 8'h00, 3};
    vecs[4]  = '{8'h80, 5'd31, 1'b0, 1'b1, 0, 8'hFF, 6};
    vecs[5]  = '{8'h80, 5'd31, 1'b0, 1'b0, 0, 8'h00, 6};
    vecs[6]  = '{8'h5B, 5'd7,  1'b1, 1'b0, 0, 8'h80, 2};
    vecs[7]  = '{8'hC3, 5'd8,  1'b0, 1'b1, 0, 8'hFF, 3};
    vecs[8]  = '{8'h43, 5'd14, 1'b0, 1'b1, 0, 8'h00, 3};
    vecs[9]  = '{8'hB4, 5'd15, 1'b1, 1'b0, 4, 8'h00, 4};
    vecs[10] = '{8'hF0, 5'd4,  1'b0, 1'b1, 4, 8'hFF, 2};
    vecs[11] = '{8'h3C, 5'd2,  1'b1, 1'b1, 0, 8'hF0, 2};

    bus.req_valid = 1'b0; bus.req_din = '0; bus.req_amt = '0;
    bus.req_lr = 1'b0; bus.req_al = 1'b0; bus.resp_ready = 1'b0;
    #2;
    check("rst_req_ready", int'(bus.req_ready), 1);
    check("rst_resp_valid", int'(bus.resp_valid), 0);
    check("rst_resp_dout", int'(bus.resp_dout), 0);
    check("rst_busy", int'(busy), 0);
    @(posedge clk); #3; rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      run_req(vecs[i].din, vecs[i].amt, vecs[i].lr, vecs[i].al, vecs[i].stall,
              got, lat, nbusy);
      check($sformatf("vec%0d_dout", i), int'(got), int'(vecs[i].exp));
      check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
      check($sformatf("vec%0d_busy", i), nbusy, vecs[i].exp_lat + vecs[i].stall);
    end

    // Reset in the second SHIFT cycle of an amt=20 request.
    bus.req_valid = 1'b1; bus.req_din = 8'hA5; bus.req_amt = 5'd20;
    bus.req_lr = 1'b0; bus.req_al = 1'b1; bus.resp_ready = 1'b1;
    @(posedge clk); #1; bus.req_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_busy_before_rst", int'(busy), 1);
    #2; rst_n = 1'b0; #1;
    check("async_rst_req_ready", int'(bus.req_ready), 1);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_valid", int'(bus.resp_valid), 0);
    check("async_rst_dout", int'(bus.resp_dout), 0);
    @(posedge clk); @(posedge clk); #3; rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("no_stale_resp", int'({busy, bus.resp_valid}), 0);
    end
    bus.resp_ready = 1'b0;

    for (int i = 0; i < 40; i++) begin
      logic [7:0] d;
      logic [4:0] a;
      logic lr, al;
      int st;
      d = 8'($urandom); a = 5'($urandom); lr = 1'($urandom); al = 1'($urandom);
      st = $urandom_range(0, 2);
      run_req(d, a, lr, al, st, got, lat, nbusy);
      check($sformatf("rnd%0d_dout d=%0h a=%0d lr=%0b al=%0b", i, d, a, lr, al),
            int'(got), int'(model(d, int'(a), lr, al)));
      check($sformatf("rnd%0d_lat", i), lat, model_lat(int'(a)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
